// File: rtl/accumulator_io_pkg.sv
// Shared types and widths for the accumulator host I/O port.
package accumulator_io_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } pres_state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int STAMP_W       = 16;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; a push on a full FIFO only lands when a pop happens in the same cycle.
module io_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/accumulator_io_port.sv
// Host endpoint for the accumulator core: queued host words are held on IOIn for HOLD_CYCLES each,
// and every change on Output is captured for the host. IOPORT_TIMESTAMP_EN adds a per-capture cycle stamp.
module accumulator_io_port
    import accumulator_io_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 6
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [WIDTH-1:0]   tx_data,
    output logic [WIDTH-1:0]   IOIn,
    output logic               io_busy,
    input  logic [WIDTH-1:0]   Output,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [WIDTH-1:0]   rx_data,
    output logic               rx_overflow
`ifdef IOPORT_TIMESTAMP_EN
    ,
    output logic [STAMP_W-1:0] rx_stamp
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
`ifdef IOPORT_TIMESTAMP_EN
    localparam int RX_W  = WIDTH + STAMP_W;
`else
    localparam int RX_W  = WIDTH;
`endif

    logic             w_tx_push;
    logic             w_tx_pop;
    logic             w_tx_empty;
    logic [WIDTH-1:0] w_tx_head;
    logic [CNT_W-1:0] w_tx_count;

    assign tx_ready   = (w_tx_count != CNT_W'(DEPTH));
    assign w_tx_push  = tx_valid && tx_ready;
    assign w_tx_empty = (w_tx_count == '0);

    io_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk        (CLK),
        .reset      (reset),
        .i_push     (w_tx_push),
        .i_push_dat (tx_data),
        .i_pop      (w_tx_pop),
        .o_head     (w_tx_head),
        .o_count    (w_tx_count)
    );

    pres_state_t      r_state;
    pres_state_t      w_state_nxt;
    logic [HC_W-1:0]  r_hc;
    logic [HC_W-1:0]  w_hc_nxt;
    logic [WIDTH-1:0] r_ioin;
    logic [WIDTH-1:0] w_ioin_nxt;
    logic             w_load;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_hc    <= '0;
            r_ioin  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hc    <= w_hc_nxt;
            r_ioin  <= w_ioin_nxt;
        end
    end

    // A new word may start once the previous one has used its full window.
    assign w_load = !w_tx_empty && ((r_state == ST_IDLE) || (r_hc == '0));

    always_comb begin
        w_state_nxt = r_state;
        w_hc_nxt    = r_hc;
        w_ioin_nxt  = r_ioin;
        w_tx_pop    = 1'b0;
        if (w_load) begin
            w_tx_pop    = 1'b1;
            w_ioin_nxt  = w_tx_head;
            w_hc_nxt    = HC_W'(HOLD_CYCLES - 1);
            w_state_nxt = ST_HOLD;
        end else if (r_state == ST_HOLD) begin
            if (r_hc != '0) begin
                w_hc_nxt = r_hc - 1'b1;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    assign IOIn    = r_ioin;
    assign io_busy = (r_state == ST_HOLD) && (r_hc != '0);

    logic             r_primed;
    logic [WIDTH-1:0] r_prev;
    logic             r_overflow;
    logic             w_cap;
    logic             w_rx_pop;
    logic             w_rx_full;
    logic [RX_W-1:0]  w_rx_push_dat;
    logic [RX_W-1:0]  w_rx_head;
    logic [CNT_W-1:0] w_rx_count;

    assign w_cap     = r_primed && (Output != r_prev);
    assign rx_valid  = (w_rx_count != '0);
    assign w_rx_full = (w_rx_count == CNT_W'(DEPTH));
    assign w_rx_pop  = rx_ready && rx_valid;

    // The first cycle out of reset only learns the bus value, so a static bus is never reported.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_primed   <= 1'b0;
            r_prev     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (!r_primed) begin
                r_primed <= 1'b1;
                r_prev   <= Output;
            end else if (w_cap) begin
                r_prev <= Output;
            end
            if (w_cap && w_rx_full && !w_rx_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rx_overflow = r_overflow;

`ifdef IOPORT_TIMESTAMP_EN
    logic [STAMP_W-1:0] r_cycle;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

    assign w_rx_push_dat = {r_cycle, Output};
    assign rx_data       = w_rx_head[WIDTH-1:0];
    assign rx_stamp      = w_rx_head[RX_W-1:WIDTH];
`else
    assign w_rx_push_dat = Output;
    assign rx_data       = w_rx_head;
`endif

    io_sync_fifo #(
        .WIDTH (RX_W),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk        (CLK),
        .reset      (reset),
        .i_push     (w_cap),
        .i_push_dat (w_rx_push_dat),
        .i_pop      (w_rx_pop),
        .o_head     (w_rx_head),
        .o_count    (w_rx_count)
    );

endmodule

// File: tb/tb_accumulator_io_port.sv
// Directed and randomized bench for accumulator_io_port against a timeline/queue reference model.
module tb_accumulator_io_port;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int HOLD  = 6;

    logic             CLK;
    logic             reset;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;
    logic [WIDTH-1:0] IOIn;
    logic             io_busy;
    logic [WIDTH-1:0] Output;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_overflow;
`ifdef IOPORT_TIMESTAMP_EN
    logic [15:0]      rx_stamp;
`endif

    int checks = 0;
    int errors = 0;

    accumulator_io_port #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .IOIn        (IOIn),
        .io_busy     (io_busy),
        .Output      (Output),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_overflow (rx_overflow)
`ifdef IOPORT_TIMESTAMP_EN
        ,
        .rx_stamp    (rx_stamp)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: each word starts at the later of "one edge after it is queued"
    // and "HOLD edges after the previous word started"; captures go into a bounded queue.
    logic [15:0] m_io;
    bit          m_started;
    int          m_last_start;
    int          m_n;
    int          m_cyc;
    logic [15:0] m_txq[$];
    logic [15:0] m_rxq[$];
    int          m_rxst[$];
    bit          m_primed;
    logic [15:0] m_prev;
    bit          m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit          acc;
        logic [15:0] dummy;
        int          dummy_st;
        if (reset) begin
            m_io = '0; m_started = 0; m_last_start = 0; m_n = 0; m_cyc = 0;
            m_txq.delete(); m_rxq.delete(); m_rxst.delete();
            m_primed = 0; m_prev = '0; m_ovf = 0;
        end else begin
            m_n = m_cyc;
            m_cyc++;
            acc = tx_valid && (m_txq.size() < DEPTH);
            if (m_txq.size() > 0 && (!m_started || m_n >= m_last_start + HOLD)) begin
                m_io = m_txq.pop_front();
                m_last_start = m_n;
                m_started = 1;
            end
            if (acc) m_txq.push_back(tx_data);
            if (rx_ready && m_rxq.size() > 0) begin
                dummy = m_rxq.pop_front();
                dummy_st = m_rxst.pop_front();
            end
            if (!m_primed) begin
                m_primed = 1;
                m_prev = Output;
            end else if (Output != m_prev) begin
                if (m_rxq.size() < DEPTH) begin
                    m_rxq.push_back(Output);
                    m_rxst.push_back(m_n);
                end else begin
                    m_ovf = 1;
                end
                m_prev = Output;
            end
        end
    endtask

    task automatic check_outputs();
        chk("IOIn", 32'(IOIn), 32'(m_io));
        chk("io_busy", 32'(io_busy), 32'(m_started && (m_n - m_last_start) < HOLD - 1));
        chk("tx_ready", 32'(tx_ready), 32'(m_txq.size() < DEPTH));
        chk("rx_valid", 32'(rx_valid), 32'(m_rxq.size() > 0));
        chk("rx_overflow", 32'(rx_overflow), 32'(m_ovf));
        if (m_rxq.size() > 0) begin
            chk("rx_data", 32'(rx_data), 32'(m_rxq[0]));
`ifdef IOPORT_TIMESTAMP_EN
            chk("rx_stamp", 32'(rx_stamp), 32'(m_rxst[0] & 16'hFFFF));
`endif
        end
        if (reset) begin
            chk("reset_rx_data", 32'(rx_data), 32'h0);
`ifdef IOPORT_TIMESTAMP_EN
            chk("reset_rx_stamp", 32'(rx_stamp), 32'h0);
`endif
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic push_word(input logic [15:0] w);
        bit acc;
        acc = 0;
        tx_valid = 1'b1;
        tx_data  = w;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = tx_ready;
            step();
        end
        tx_valid = 1'b0;
        if (!acc) chk("push_timeout", 32'(acc), 32'h1);
    endtask

    initial begin
        reset = 1'b1; tx_valid = 1'b0; tx_data = '0; Output = '0; rx_ready = 1'b0;

        // Reset and first presentation
        repeat (3) step();
        chk("reset_IOIn", 32'(IOIn), 32'h0);
        reset = 1'b0;
        push_word(16'hFF00);
        step();
        chk("first_IOIn", 32'(IOIn), 32'hFF00);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("first_busy", 32'(io_busy), 32'h1);
        end
        step();
        chk("first_busy_end", 32'(io_busy), 32'h0);
        repeat (3) step();

        // Back-to-back TX
        push_word(16'h0014);
        push_word(16'h000A);
        push_word(16'h0800);
        repeat (25) step();
        chk("b2b_final", 32'(IOIn), 32'h0800);

        // TX full: keep the presenter busy while queueing five more
        push_word(16'h1111);
        step();
        push_word(16'h2222);
        push_word(16'h3333);
        push_word(16'h4444);
        push_word(16'h5555);
        chk("tx_full", 32'(tx_ready), 32'h0);
        push_word(16'h6666);
        repeat (40) step();
        chk("tx_full_last", 32'(IOIn), 32'h6666);

        // Capture dedup
        rx_ready = 1'b0;
        Output = 16'h001E;
        step();
        chk("dedup_first_vld", 32'(rx_valid), 32'h1);
        repeat (4) step();
        Output = 16'h0001;
        repeat (3) step();
        rx_ready = 1'b1;
        chk("dedup_head0", 32'(rx_data), 32'h001E);
        step();
        chk("dedup_head1", 32'(rx_data), 32'h0001);
        step();
        chk("dedup_empty", 32'(rx_valid), 32'h0);

        // RX overflow, then push+pop on a full FIFO
        rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Output = 16'h0100 + 16'(i);
            step();
        end
        chk("ovf_set", 32'(rx_overflow), 32'h1);
        chk("ovf_head", 32'(rx_data), 32'h0100);
        rx_ready = 1'b1;
        Output = 16'h0105;
        step();
        chk("ovf_pushpop_head", 32'(rx_data), 32'h0101);
        repeat (3) step();
        chk("ovf_sixth", 32'(rx_data), 32'h0105);
        step();
        chk("ovf_sticky", 32'(rx_overflow), 32'h1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            tx_valid = 1'($urandom_range(0, 2) == 0);
            tx_data  = 16'($urandom);
            Output   = 16'($urandom_range(0, 3)) << 4;
            rx_ready = 1'($urandom_range(0, 1));
            step();
        end
        reset = 1'b0; tx_valid = 1'b0;

`ifdef IOPORT_TIMESTAMP_EN
        reset = 1'b1; rx_ready = 1'b0; Output = 16'h0055;
        step();
        reset = 1'b0;
        repeat (10) step();
        Output = 16'h0066;
        step();
        chk("stamp10", 32'(rx_stamp), 32'd10);
        Output = 16'h0077;
        push_word(16'hABCD);
        reset = 1'b1;
        step();
        chk("midreset_rx_valid", 32'(rx_valid), 32'h0);
        chk("midreset_tx_ready", 32'(tx_ready), 32'h1);
        reset = 1'b0; Output = 16'h0088;
        step();
        Output = 16'h0099;
        step();
        chk("stamp_restart", 32'(rx_stamp), 32'd1);
`endif

        // Overflow clears only through reset
        reset = 1'b1;
        step();
        chk("ovf_cleared", 32'(rx_overflow), 32'h0);
        reset = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
